apb_slave_bridge: RTL and testbench

- Parametrised APB4 slave front-end between the system APB and a word-addressed register file, e.g. the UART CSR block.
- Converts APB setup/access phases into a single-cycle register request, then waits for a register-side ack or error.
- Adds wait-state support, byte strobes, address decode/alignment errors and an optional response timeout.
- Returns a registered pready/prdata/pslverr response.

---
 rtl/apb_slave_pkg.sv | 37 +++
 rtl/apb_slave_bridge.sv | 194 +++++++++++++++++++
 tb/tb_apb_slave_bridge.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB4 slave bridge.
//
// Contents:
//   apb_state_e  - bridge FSM states (idle, issue, wait, response)
//   apb_req_t    - captured APB request (address, direction, data, strobes, error flag)
//   strb_w()     - byte-strobe width for a given data width
//   TO_CNT_W     - width of the optional response-timeout counter
//
// The request struct is sized for the widest supported configuration (32-bit address,
// 64-bit data); the bridge zero-extends into it and slices back out.
package apb_slave_pkg;

  localparam int unsigned TO_CNT_W   = 16;
  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 64;
  localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  write;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] strb;
    logic                  err;
  } apb_req_t;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_slave_bridge.sv
// APB4 slave front-end for a word-addressed register file.
//
// An APB setup phase is captured and decoded; legal requests become a single-cycle
// reg_wr_en/reg_rd_en pulse, after which the bridge waits for reg_ack (with reg_err).
// The APB response (pready/pslverr/prdata) is registered and lasts exactly one cycle.
// Unaligned or out-of-range addresses are answered with pslverr without touching the
// register side.
//
// Optional build macro: APB_TIMEOUT_EN - adds a 16-bit response timeout that terminates
// a transfer with pslverr after TIMEOUT_CYC cycles without reg_ack.
//
// Ports:
//   pclk, prst_n                  clock, asynchronous active-low reset
//   paddr/psel/penable/pwrite/
//   pwdata/pstrb                  APB request
//   pready/prdata/pslverr         APB response (registered)
//   reg_wr_en/reg_rd_en           one-cycle register request pulses
//   reg_addr/reg_wdata/reg_strb   registered request fields, stable until response ends
//   reg_rdata/reg_ack/reg_err     register-side completion
//   busy                          bridge is not idle
//
// ADDR_W must not exceed 32; DATA_W must be 32 or 64.
module apb_slave_bridge
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned STRB_W     = strb_w(DATA_W)
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [STRB_W-1:0] reg_strb,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  input  logic              reg_err,
  output logic              busy
);

  localparam int unsigned AlignW    = $clog2(STRB_W);
  localparam int unsigned AddrLimit = NUM_REGS * STRB_W;

  apb_state_e        state_q, state_d;
  apb_req_t          req_q, req_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;

  // Address decode of the live setup-phase address.
  logic [REQ_ADDR_W-1:0] paddr_ext;
  logic                  dec_err;

  assign paddr_ext = REQ_ADDR_W'(paddr);
  assign dec_err   = (paddr[AlignW-1:0] != '0) ||
                     (paddr_ext >= REQ_ADDR_W'(AddrLimit));

`ifdef APB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + TO_CNT_W'(1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_CNT_W'(TIMEOUT_CYC);
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    prdata_d  = '0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Only a genuine setup phase starts a transfer; a bare access phase is ignored.
        if (psel && !penable) begin
          req_d.addr  = paddr_ext;
          req_d.write = pwrite;
          req_d.wdata = REQ_DATA_W'(pwdata);
          req_d.strb  = pwrite ? REQ_STRB_W'(pstrb) : '0;
          req_d.err   = dec_err;
          if (dec_err) begin
            state_d = StResp;
          end else begin
            state_d = StIssue;
            wr_en_d = pwrite;
            rd_en_d = !pwrite;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      StIssue, StWait: begin
        // APB handshake is not consulted here: once issued, the transfer always completes.
        if (reg_ack) begin
          state_d   = StResp;
          req_d.err = reg_err;
          prdata_d  = (!req_q.write && !reg_err) ? reg_rdata : '0;
`ifdef APB_TIMEOUT_EN
        end else if (cnt_inc == TO_CNT_W'(TIMEOUT_CYC)) begin
          // reg_ack on the terminal cycle takes the branch above instead.
          state_d   = StResp;
          req_d.err = 1'b1;
        end else begin
          state_d   = StWait;
          cnt_d     = cnt_inc;
`else
        end else begin
          state_d   = StWait;
`endif
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    pready_d  = (state_d == StResp);
    pslverr_d = pready_d && req_d.err;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = req_q.addr[ADDR_W-1:0];
  assign reg_wdata = req_q.wdata[DATA_W-1:0];
  assign reg_strb  = req_q.strb[STRB_W-1:0];
  assign busy      = busy_q;

  // Upper bits of the widest-case request struct are always zero for narrower builds.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_q.addr >> ADDR_W, req_q.wdata >> DATA_W,
                             req_q.strb >> STRB_W};

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Directed bench for apb_slave_bridge (32-bit data, 16 registers, timeout of 4 cycles
// when built with APB_TIMEOUT_EN). Each task drives one scenario cycle by cycle and
// checks registered outputs 1 ns after the rising edge.
module tb_apb_slave_bridge;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b1;
  logic [11:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_strb;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_slave_bridge #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .NUM_REGS    (16),
    .TIMEOUT_CYC (4)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_strb  (reg_strb),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .reg_err   (reg_err),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_setup(input logic [11:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
  endtask

  task automatic apb_idle();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #2 prst_n = 1'b0;
    tick(); tick();
    checks++; if ({pready, pslverr, reg_wr_en, reg_rd_en, busy} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got=%b exp=00000",
                         {pready, pslverr, reg_wr_en, reg_rd_en, busy}); end
    checks++; if (prdata !== 32'h0) begin
      errors++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
    checks++; if ({reg_addr, reg_wdata, reg_strb} !== 48'h0) begin
      errors++; $display("FAIL rst_reg_fields got=%h exp=0", {reg_addr, reg_wdata, reg_strb}); end
    prst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_fast();
    apb_setup(12'h008, 1'b1, 32'hDEADBEEF, 4'hF);
    tick(); // ISSUE
    penable = 1'b1; reg_ack = 1'b1;
    checks++; if ({reg_wr_en, reg_rd_en} !== 2'b10) begin
      errors++; $display("FAIL wr_pulse got=%b exp=10", {reg_wr_en, reg_rd_en}); end
    checks++; if (reg_addr !== 12'h008) begin
      errors++; $display("FAIL wr_addr got=%h exp=008", reg_addr); end
    checks++; if (reg_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_wdata got=%h exp=deadbeef", reg_wdata); end
    checks++; if (reg_strb !== 4'hF) begin
      errors++; $display("FAIL wr_strb got=%h exp=f", reg_strb); end
    checks++; if ({pready, busy} !== 2'b01) begin
      errors++; $display("FAIL wr_issue_pready_busy got=%b exp=01", {pready, busy}); end
    tick(); // RESP
    reg_ack = 1'b0;
    checks++; if ({pready, pslverr, reg_wr_en} !== 3'b100) begin
      errors++; $display("FAIL wr_resp got=%b exp=100", {pready, pslverr, reg_wr_en}); end
    checks++; if (prdata !== 32'h0) begin
      errors++; $display("FAIL wr_prdata got=%h exp=0", prdata); end
    apb_idle();
    tick();
    checks++; if ({pready, busy} !== 2'b00) begin
      errors++; $display("FAIL wr_after got=%b exp=00", {pready, busy}); end
  endtask

  task automatic test_read_wait();
    apb_setup(12'h010, 1'b0, 32'hCAFEF00D, 4'hF);
    tick(); // T1 ISSUE
    penable = 1'b1;
    checks++; if ({reg_wr_en, reg_rd_en} !== 2'b01) begin
      errors++; $display("FAIL rd_pulse got=%b exp=01", {reg_wr_en, reg_rd_en}); end
    checks++; if (reg_strb !== 4'h0) begin
      errors++; $display("FAIL rd_strb got=%h exp=0", reg_strb); end
    checks++; if (reg_addr !== 12'h010) begin
      errors++; $display("FAIL rd_addr got=%h exp=010", reg_addr); end
    tick(); // T2 WAIT
    checks++; if ({reg_rd_en, pready, busy} !== 3'b001) begin
      errors++; $display("FAIL rd_wait got=%b exp=001", {reg_rd_en, pready, busy}); end
    tick(); // T3 WAIT
    tick(); // T4 WAIT, ack now
    reg_ack = 1'b1; reg_rdata = 32'h12345678;
    checks++; if ({pready, prdata} !== 33'h0) begin
      errors++; $display("FAIL rd_before got=%h exp=0", {pready, prdata}); end
    tick(); // T5 RESP
    reg_ack = 1'b0; reg_rdata = 32'hFFFF0000;
    checks++; if ({pready, pslverr} !== 2'b10) begin
      errors++; $display("FAIL rd_resp got=%b exp=10", {pready, pslverr}); end
    checks++; if (prdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_prdata got=%h exp=12345678", prdata); end
    apb_idle();
    tick(); // T6
    checks++; if ({pready, prdata} !== 33'h0) begin
      errors++; $display("FAIL rd_after got=%h exp=0", {pready, prdata}); end
  endtask

  task automatic test_decode_err();
    reg_rdata = 32'hA5A5A5A5;
    apb_setup(12'h040, 1'b0, 32'h0, 4'h0); // one past the last register
    tick();
    penable = 1'b1;
    checks++; if ({pready, pslverr, reg_rd_en, reg_wr_en} !== 4'b1100) begin
      errors++; $display("FAIL oor_resp got=%b exp=1100",
                         {pready, pslverr, reg_rd_en, reg_wr_en}); end
    checks++; if (prdata !== 32'h0) begin
      errors++; $display("FAIL oor_prdata got=%h exp=0", prdata); end
    apb_idle();
    tick();
    checks++; if ({pready, reg_rd_en, reg_wr_en, busy} !== 4'b0) begin
      errors++; $display("FAIL oor_after got=%b exp=0000",
                         {pready, reg_rd_en, reg_wr_en, busy}); end
    apb_setup(12'h006, 1'b1, 32'h55AA55AA, 4'hF); // unaligned
    tick();
    penable = 1'b1;
    checks++; if ({pready, pslverr, reg_rd_en, reg_wr_en} !== 4'b1100) begin
      errors++; $display("FAIL unal_resp got=%b exp=1100",
                         {pready, pslverr, reg_rd_en, reg_wr_en}); end
    apb_idle();
    tick();
    checks++; if ({pready, reg_wr_en} !== 2'b0) begin
      errors++; $display("FAIL unal_after got=%b exp=00", {pready, reg_wr_en}); end
    // Last legal word must be issued normally.
    apb_setup(12'h03C, 1'b0, 32'h0, 4'h0);
    tick();
    penable = 1'b1; reg_ack = 1'b1; reg_rdata = 32'h0BADF00D;
    checks++; if ({reg_rd_en, pready} !== 2'b10) begin
      errors++; $display("FAIL last_issue got=%b exp=10", {reg_rd_en, pready}); end
    tick();
    reg_ack = 1'b0;
    checks++; if ({pready, pslverr, prdata} !== {2'b10, 32'h0BADF00D}) begin
      errors++; $display("FAIL last_resp got=%h exp=%h", {pready, pslverr, prdata},
                         {2'b10, 32'h0BADF00D}); end
    apb_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    apb_setup(12'h00C, 1'b1, 32'h01020304, 4'h0);
    tick(); // T1 ISSUE, error ack
    penable = 1'b1; reg_ack = 1'b1; reg_err = 1'b1;
    checks++; if ({reg_wr_en, reg_strb} !== 5'b10000) begin
      errors++; $display("FAIL b2b_wr got=%b exp=10000", {reg_wr_en, reg_strb}); end
    tick(); // T2 RESP
    reg_ack = 1'b0; reg_err = 1'b0;
    checks++; if ({pready, pslverr, prdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL b2b_err_resp got=%h exp=%h", {pready, pslverr, prdata},
                         {2'b11, 32'h0}); end
    tick(); // T3 setup of first read
    apb_setup(12'h000, 1'b0, 32'h0, 4'h0);
    checks++; if ({pready, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b_gap got=%b exp=00", {pready, busy}); end
    tick(); // T4 ISSUE
    penable = 1'b1; reg_ack = 1'b1; reg_rdata = 32'h11112222;
    checks++; if ({reg_rd_en, reg_addr} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL b2b_rd1_issue got=%h exp=1000", {reg_rd_en, reg_addr}); end
    tick(); // T5 RESP
    reg_ack = 1'b0;
    checks++; if ({pready, pslverr, prdata} !== {2'b10, 32'h11112222}) begin
      errors++; $display("FAIL b2b_rd1_resp got=%h exp=%h", {pready, pslverr, prdata},
                         {2'b10, 32'h11112222}); end
    tick(); // T6 setup of second read
    apb_setup(12'h004, 1'b0, 32'h0, 4'h0);
    checks++; if (pready !== 1'b0) begin
      errors++; $display("FAIL b2b_single_pready got=%b exp=0", pready); end
    tick(); // T7 ISSUE
    penable = 1'b1; reg_ack = 1'b1; reg_rdata = 32'h33334444;
    checks++; if ({reg_rd_en, reg_addr} !== {1'b1, 12'h004}) begin
      errors++; $display("FAIL b2b_rd2_issue got=%h exp=1004", {reg_rd_en, reg_addr}); end
    tick(); // T8 RESP
    reg_ack = 1'b0;
    checks++; if ({pready, prdata} !== {1'b1, 32'h33334444}) begin
      errors++; $display("FAIL b2b_rd2_resp got=%h exp=%h", {pready, prdata},
                         {1'b1, 32'h33334444}); end
    apb_idle();
    tick();
    checks++; if (pready !== 1'b0) begin
      errors++; $display("FAIL b2b_end got=%b exp=0", pready); end
  endtask

  task automatic test_idle_access_ignored();
    psel = 1'b1; penable = 1'b1; paddr = 12'h008; pwrite = 1'b1;
    tick();
    tick();
    checks++; if ({busy, reg_wr_en, reg_rd_en, pready} !== 4'b0) begin
      errors++; $display("FAIL bare_access got=%b exp=0000",
                         {busy, reg_wr_en, reg_rd_en, pready}); end
    apb_idle();
    tick();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    apb_setup(12'h020, 1'b0, 32'h0, 4'h0);
    tick(); // T1 ISSUE
    penable = 1'b1; reg_rdata = 32'h77777777;
    tick(); // T2
    tick(); // T3
    tick(); // T4
    checks++; if (pready !== 1'b0) begin
      errors++; $display("FAIL to_early got=%b exp=0", pready); end
    tick(); // T5 RESP by timeout
    checks++; if ({pready, pslverr, prdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL to_resp got=%h exp=%h", {pready, pslverr, prdata},
                         {2'b11, 32'h0}); end
    apb_idle();
    tick(); // T6 late ack
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    checks++; if ({pready, busy, reg_rd_en} !== 3'b0) begin
      errors++; $display("FAIL to_late_ack got=%b exp=000", {pready, busy, reg_rd_en}); end
    tick();
    checks++; if (pready !== 1'b0) begin
      errors++; $display("FAIL to_no_second got=%b exp=0", pready); end
  endtask
`endif

  task automatic test_reset_mid();
    apb_setup(12'h004, 1'b0, 32'h0, 4'h0);
    tick(); // ISSUE
    penable = 1'b1;
    tick(); // WAIT
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #2 prst_n = 1'b0;
    #1;
    checks++; if ({busy, pready, reg_rd_en, reg_addr} !== 15'h0) begin
      errors++; $display("FAIL mid_async got=%h exp=0", {busy, pready, reg_rd_en, reg_addr}); end
    tick();
    prst_n = 1'b1;
    apb_idle();
    reg_ack = 1'b1; reg_rdata = 32'hDEAD0000;
    tick();
    reg_ack = 1'b0;
    checks++; if ({pready, busy, reg_rd_en} !== 3'b0) begin
      errors++; $display("FAIL mid_stray_ack got=%b exp=000", {pready, busy, reg_rd_en}); end
    tick();
    checks++; if ({pready, prdata} !== 33'h0) begin
      errors++; $display("FAIL mid_no_resp got=%h exp=0", {pready, prdata}); end
    test_write_fast();
  endtask

  initial begin
    test_reset();
    test_write_fast();
    test_read_wait();
    test_decode_err();
    test_back_to_back();
    test_idle_access_ignored();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
